// File: rtl/bcd_seq.sv
// bcd_seq: sequential binary-to-BCD converter for the stopwatch display path.
// One restoring shift-subtract divide-by-10 datapath is reused for every digit.
// Each digit takes BITS shift steps plus one store cycle, so a conversion
// always takes DIGITS*(BITS+1) cycles, whatever the input value.
// Optional feature: define BCD_SEQ_SAT_EN to show all nines for inputs that
// do not fit in DIGITS decimal digits. Without it, the display shows the
// value modulo 10^DIGITS. The overflow flag is set in both builds.
module bcd_seq #(
    parameter int BITS   = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BITS-1:0]       number,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   digits,
    output logic                  overflow
);

    localparam int          STEP_W = (BITS > 1) ? $clog2(BITS) : 1;
    localparam int          DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [31:0] LIMIT  = 32'(10 ** DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_STORE
    } state_t;

    state_t                state_q;
    logic [BITS-1:0]       q_q;        // dividend, becomes the quotient bit by bit
    logic [3:0]            r_q;        // partial remainder, always < 10
    logic [STEP_W-1:0]     step_q;
    logic [DIG_W-1:0]      dig_q;
    logic                  ovf_pend_q;
    logic [4*DIGITS-1:0]   shadow_q;   // digits collected during the conversion
    logic [4*DIGITS-1:0]   digits_q;
    logic                  overflow_q;
    logic                  busy_q;
    logic                  done_q;

    logic [4:0]            t;
    logic                  t_ge;
    logic [3:0]            r_d;
    logic [BITS-1:0]       q_d;
    logic [3:0]            store_val;
    logic [4*DIGITS-1:0]   shadow_d;
    logic                  ovf_in;
    logic                  last_step;
    logic                  last_digit;

    // Trial subtraction for one divide step and the shadow value for the digit being stored.
    always_comb begin
        // NOTE: every output of this block gets a value first, so no path leaves one unassigned and no latch is inferred.
        t         = {r_q, q_q[BITS-1]};
        t_ge      = (t >= 5'd10);
        r_d       = t_ge ? 4'(t - 5'd10) : t[3:0];
        q_d       = {q_q[BITS-2:0], t_ge};
`ifdef BCD_SEQ_SAT_EN
        store_val = ovf_pend_q ? 4'd9 : r_q;
`else
        store_val = r_q;
`endif
        shadow_d  = shadow_q;
        shadow_d[int'(dig_q)*4 +: 4] = store_val;
        ovf_in     = (32'(number) >= LIMIT);
        last_step  = (step_q == STEP_W'(BITS - 1));
        last_digit = (dig_q == DIG_W'(DIGITS - 1));
    end

    // Control FSM and datapath registers. All outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shadow and output digit registers are reset too. The display must read zero after any reset, even one that hits mid-conversion.
            state_q    <= S_IDLE;
            q_q        <= '0;
            r_q        <= '0;
            step_q     <= '0;
            dig_q      <= '0;
            ovf_pend_q <= 1'b0;
            shadow_q   <= '0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every register samples the pre-edge values, whatever order the statements are in.
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        q_q        <= number;
                        r_q        <= '0;
                        step_q     <= '0;
                        dig_q      <= '0;
                        ovf_pend_q <= ovf_in;
                        busy_q     <= 1'b1;
                        state_q    <= S_STEP;
                    end
                end
                S_STEP: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (last_step) begin
                        step_q  <= '0;
                        state_q <= S_STORE;
                    end else begin
                        step_q <= step_q + 1'b1;
                    end
                end
                S_STORE: begin
                    // q_q already holds the quotient, which is the dividend for the next digit.
                    shadow_q <= shadow_d;
                    r_q      <= '0;
                    step_q   <= '0;
                    if (last_digit) begin
                        digits_q   <= shadow_d;
                        overflow_q <= ovf_pend_q;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end else begin
                        dig_q   <= dig_q + 1'b1;
                        state_q <= S_STEP;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign digits   = digits_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_seq.sv
// Self-checking bench for bcd_seq. It compares the DUT against an arithmetic
// reference model that uses modulo and divide-by-10. Compile with the same
// BCD_SEQ_SAT_EN setting as the RTL.
module tb_bcd_seq;

    localparam int BITS   = 14;
    localparam int DIGITS = 4;
    localparam int LAT    = DIGITS * (BITS + 1);
    localparam int LIMIT  = 10 ** DIGITS;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [BITS-1:0]     number;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] digits;
    logic                overflow;

    int n_checks = 0;
    int n_pass   = 0;
    bit overlap_seen = 1'b0;

    bcd_seq #(.BITS(BITS), .DIGITS(DIGITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .number   (number),
        .busy     (busy),
        .done     (done),
        .digits   (digits),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // busy and done must never be high in the same cycle.
    always @(negedge clk) if (busy && done) overlap_seen = 1'b1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: decimal digits of the value, modulo 10^DIGITS or clamped to all nines.
    function automatic logic [4*DIGITS-1:0] model_digits(input int n);
        int v;
        logic [4*DIGITS-1:0] res;
`ifdef BCD_SEQ_SAT_EN
        v = (n >= LIMIT) ? LIMIT - 1 : n;
`else
        v = n % LIMIT;
`endif
        res = '0;
        for (int i = 0; i < DIGITS; i++) begin
            res[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return res;
    endfunction

    // One conversion. Optionally pulses start with a new number poke_at cycles after acceptance.
    task automatic run_conv(input string name, input int n, input int poke_at, input int poke_num);
        int lat;
        int extra_dones;
        bit done_seen;
        bit busy_ok;
        number = BITS'(n);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({name, "_busy_rise"}, busy, 1);
        lat = 0;
        done_seen = 1'b0;
        busy_ok = 1'b1;
        while (!done_seen && lat < LAT + 20) begin
            if (lat == poke_at) begin
                start  = 1'b1;
                number = BITS'(poke_num);
            end
            tick();
            lat++;
            if (lat == poke_at + 1) start = 1'b0;
            if (done) done_seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        check({name, "_done_seen"}, done_seen, 1);
        check({name, "_latency"}, lat, LAT);
        check({name, "_busy_held"}, busy_ok, 1);
        check({name, "_busy_fall"}, busy, 0);
        check({name, "_digits"}, digits, model_digits(n));
        check({name, "_overflow"}, overflow, (n >= LIMIT) ? 1 : 0);
        tick();
        check({name, "_done_width"}, done, 0);
        if (poke_at >= 0) begin
            extra_dones = 0;
            for (int i = 0; i < LAT + 10; i++) begin
                tick();
                if (done) extra_dones++;
            end
            check({name, "_no_extra_done"}, extra_dones, 0);
            check({name, "_digits_hold"}, digits, model_digits(n));
        end
    endtask

    initial begin
        int n;
        int dones;
        int first;
        int second;
        bit bad;

        rst_n  = 1'b0;
        start  = 1'b0;
        number = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_digits", digits, 0);
        check("rst_overflow", overflow, 0);
        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", busy, 0);
        check("idle_digits", digits, 0);

        run_conv("zero", 0, -1, 0);
        run_conv("n1234", 1234, -1, 0);
        run_conv("n9999", 9999, -1, 0);
        run_conv("n16383", 16383, -1, 0);
        run_conv("n10000", 10000, -1, 0);
        run_conv("n12345", 12345, -1, 0);
        run_conv("poke", 4321, 20, 5);

        for (int i = 0; i < 16; i++) begin
            n = int'($urandom_range(0, (1 << BITS) - 1));
            run_conv("rand", n, -1, 0);
        end

        // Reset in the middle of a conversion.
        number = BITS'(1234);
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_digits", digits, 0);
        check("midrst_overflow", overflow, 0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < LAT + 40; i++) begin
            tick();
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        check("midrst_idle_busy", busy, 0);

        // start held high: back-to-back conversions.
        number = BITS'(42);
        start  = 1'b1;
        tick();
        first  = -1;
        second = -1;
        bad    = 1'b0;
        for (int c = 1; c <= 135; c++) begin
            tick();
            if (done) begin
                if (first < 0) first = c;
                else if (second < 0) second = c;
            end
            if (first >= 0 && digits !== 16'h0042) bad = 1'b1;
        end
        start = 1'b0;
        check("held_first_done", first, LAT);
        check("held_second_done", second, 2 * LAT + 1);
        check("held_digits_stable", bad, 0);
        for (int i = 0; i < LAT + 10 && busy; i++) tick();
        tick();
        check("held_drained", busy, 0);

        check("busy_done_overlap", overlap_seen, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_seq.md
# bcd_seq

Sequential binary-to-BCD converter for the stopwatch display path. Time-shares one restoring shift-subtract divide-by-10 datapath over all digits under a small FSM, replacing the per-digit combinational divider chain in front of the 7-segment scanner. Accepts a 14-bit count on a start pulse and returns four packed BCD digits with a one-cycle done strobe. The display scanner reads `digits`, which hold their value between conversions.

## Interface
- `BITS`, 14, width of the binary input and of the quotient shift register.
- `DIGITS`, 4, number of BCD digits produced; `digits` is 4*DIGITS wide.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: conversion request, sampled only in IDLE.
- `number` input BITS: binary value, captured on the accepting edge.
- `busy` output 1: high while a conversion is in progress.
- `done` output 1: one-cycle pulse when `digits` and `overflow` update.
- `digits` output 4*DIGITS: packed BCD, digit 0 (units) in [3:0].
- `overflow` output 1: last captured number was ≥ 10^DIGITS.

## Operation
- States:
  - IDLE: on `start`=1, capture `number` into quotient register `q`, clear remainder `r`, clear step and digit counters, set `ovf_pend` = (number ≥ 10^DIGITS), go to STEP.
  - STEP: form t = {r, q[BITS-1]} (5 bits). If t ≥ 10, then r ← t−10 and shift 1 into q LSB; else r ← t and shift 0. After BITS steps go to STORE.
  - STORE: write `r` into the digit-index slot of the shadow register. `q` keeps the quotient, which becomes the next dividend; clear `r` and the step counter.
    - Not last digit: increment the digit index, go to STEP.
    - Last digit: copy shadow to `digits`, set `overflow`, pulse `done`, go to IDLE.
- `r` is 4 bits and always < 10; `t` is 5 bits; the compare is unsigned.
- `start` while busy is ignored; no queuing.
- `start` in the IDLE cycle that carries `done` is accepted normally.
- `number` changes after capture have no effect on the conversion.
- `digits` never shows a partial result; it changes only at the `done` edge.
- Reset, including mid-conversion: state IDLE; `busy`=0, `done`=0, `digits`=0, `overflow`=0; internal registers cleared.

## Timing
- Start accepted at edge k: `busy`=1 from edge k.
- Digit d is stored at edge k + (d+1)·(BITS+1).
- `digits`, `overflow` and `done` update at edge k + DIGITS·(BITS+1), which is k+60 with defaults. `busy` falls at the same edge.
- Latency is 60 cycles for any input value.
- `done` is high for exactly one cycle.
- Back-to-back: with `start` held high, a new conversion is accepted at edge k+61. Throughput is one conversion per 61 cycles.
- `busy` and `done` are never high in the same cycle.

## Configuration
- Macro `BCD_SEQ_SAT_EN`.
- Defined: when `ovf_pend`=1, STORE writes 9 into every digit. Out-of-range input shows 9999.
- Undefined: digits are the natural result, number mod 10^DIGITS. For example, 12345 shows 2345.
- `overflow` is flagged in both builds.

## Test plan
- Reset release, then `start` with `number`=0: `done` at k+60, `digits`=16'h0000, `overflow`=0.
- `number`=1234: `busy` high for 60 cycles, then `digits`=16'h1234 with a one-cycle `done`.
- `number`=9999, then `number`=16383:
  - 9999 gives 16'h9999, `overflow`=0.
  - 16383 with `BCD_SEQ_SAT_EN` gives 16'h9999, `overflow`=1.
  - 16383 without the macro gives 16'h6383, `overflow`=1.
- Start with 4321. At k+20, pulse `start` and change `number` to 5. Result is 16'h4321, with only one `done`.
- Start with 1234. Assert `rst_n`=0 at k+30: outputs zero immediately. After release with no `start`, `done` never fires.
- `start` held high with `number`=42:
  - First `done` at k+60, second at k+121.
  - `digits` = 16'h0042 throughout after the first `done`.
